// File: rtl/gray_clk_gen.sv
// gray_clk_gen: head-of-chain Gray-code clock generator.
// Drives the Gray phase bus, the saturated toggle index and clkdiv2 for the
// channel chain. Counting is framed: start launches a run, stop drains the
// counter to the next frame boundary so the chain always parks at code 0.
module gray_clk_gen #(
    parameter int N_GRAY = 10,
    parameter int NOB_W  = 3
) (
    input  logic              clk_master,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              ud_en,
    output logic [N_GRAY-1:0] gray_clk_out,
    output logic [NOB_W-1:0]  no_ones_below_out,
    output logic              clkdiv2,
    output logic              frame_strb,
    output logic              busy
);

    localparam int unsigned IDX_CLAMP = N_GRAY - 1;
    localparam int unsigned IDX_SAT   = (1 << NOB_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [N_GRAY-1:0] cnt;
    logic [N_GRAY-1:0] cnt_nx;
    logic              dir;
    logic              dir_nx;
    logic              adv;
    logic              wrap;

    // Index of the Gray bit that flips on the next advance: trailing ones
    // when counting up, trailing zeros when counting down, clamped then
    // saturated to the output width.
    function automatic logic [NOB_W-1:0] toggle_idx(input logic [N_GRAY-1:0] c,
                                                    input logic              up);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int unsigned i = 0; i < N_GRAY; i++) begin
            if (run && (c[i] == up)) n++;
            else                     run = 1'b0;
        end
        if (n > IDX_CLAMP) n = IDX_CLAMP;
        if (n > IDX_SAT)   n = IDX_SAT;
        return n[NOB_W-1:0];
    endfunction

    // Next-state decode: FSM priority, advance enable and frame wrap.
    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        adv      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    dir_nx   = ud_en;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                adv = 1'b1;
                if (stop) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A start cancels the drain on this edge without advancing.
                if (start) state_nx = ST_RUN;
                else       adv      = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
        cnt_nx = cnt;
        if (adv) cnt_nx = dir ? (cnt + 1'b1) : (cnt - 1'b1);
        wrap = adv && (cnt_nx == '0);
        if ((state == ST_DRAIN) && wrap) state_nx = ST_IDLE;
    end

    // State and registered outputs; outputs are derived from the next count
    // so they change on the same edge as cnt.
    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            dir               <= 1'b1;
            gray_clk_out      <= '0;
            no_ones_below_out <= '0;
            clkdiv2           <= 1'b0;
            frame_strb        <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            dir               <= dir_nx;
            gray_clk_out      <= cnt_nx ^ (cnt_nx >> 1);
            no_ones_below_out <= toggle_idx(cnt_nx, dir_nx);
            clkdiv2           <= cnt_nx[0];
            frame_strb        <= wrap;
            busy              <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_gray_clk_gen.sv
// tb_gray_clk_gen: directed self-checking bench for gray_clk_gen.
module tb_gray_clk_gen;

    localparam int N_GRAY = 10;
    localparam int NOB_W  = 3;

    logic              clk_master = 1'b0;
    logic              rst        = 1'b0;
    logic              start      = 1'b0;
    logic              stop       = 1'b0;
    logic              ud_en      = 1'b1;
    logic [N_GRAY-1:0] gray_clk_out;
    logic [NOB_W-1:0]  no_ones_below_out;
    logic              clkdiv2;
    logic              frame_strb;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    gray_clk_gen #(
        .N_GRAY(N_GRAY),
        .NOB_W (NOB_W)
    ) dut (
        .clk_master       (clk_master),
        .rst              (rst),
        .start            (start),
        .stop             (stop),
        .ud_en            (ud_en),
        .gray_clk_out     (gray_clk_out),
        .no_ones_below_out(no_ones_below_out),
        .clkdiv2          (clkdiv2),
        .frame_strb       (frame_strb),
        .busy             (busy)
    );

    // 10-time-unit master clock
    always #5 clk_master = ~clk_master;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gray_of(input int unsigned k);
        return k ^ (k >> 1);
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk_master);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {17'd0, gray_clk_out, no_ones_below_out, clkdiv2, frame_strb, busy}, 32'd0);
    endtask

    // Runs a drain already started by a stop edge until the DUT signals the
    // frame boundary, bounded so a stuck drain is reported, not hung on.
    task automatic drain_to_zero(input string tag, input int exp_len);
        int adv;
        adv = 1;
        while (!frame_strb && adv <= 1100) begin
            cyc();
            adv++;
            if (!frame_strb) check({tag, "_busy"}, busy, 1);
        end
        check({tag, "_len"},   adv,          exp_len);
        check({tag, "_strb"},  frame_strb,   1);
        check({tag, "_idle"},  busy,         0);
        check({tag, "_gray0"}, gray_clk_out, 0);
    endtask

    initial begin
        int unsigned    k;
        int             pulses;
        int             bi;
        logic [N_GRAY-1:0] pg;
        logic [N_GRAY-1:0] diff;
        logic [NOB_W-1:0]  pn;

        // Reset asserted with no clock edge in between
        #1 rst = 1'b1;
        #1 check_all_zero("reset_async");
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check_all_zero("reset_hold");
        end

        // Up counting launch
        ud_en = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("up_busy", busy, 1);
        check("up_gray_start", gray_clk_out, 0);
        cyc(); cyc(); cyc();
        check("up3_gray", gray_clk_out, 32'b010);
        check("up3_idx", no_ones_below_out, 2);
        check("up3_div2", clkdiv2, 1);
        cyc();
        check("up4_gray", gray_clk_out, 32'b110);
        check("up4_idx", no_ones_below_out, 0);

        // One full frame of advances starting from cnt=4
        k = 4;
        pulses = 0;
        for (int i = 0; i < 1024; i++) begin
            pg = gray_clk_out;
            pn = no_ones_below_out;
            cyc();
            k = (k + 1) % 1024;
            diff = gray_clk_out ^ pg;
            check("frame_gray", gray_clk_out, gray_of(k));
            check("frame_onehot", $countones(diff), 1);
            bi = 0;
            for (int b = 0; b < N_GRAY; b++) if (diff[b]) bi = b;
            check("frame_idx", pn, (bi > 7) ? 7 : bi);
            check("frame_strb_at0", frame_strb, (k == 0) ? 1 : 0);
            if (frame_strb) pulses++;
        end
        check("frame_pulses", pulses, 1);

        // Drain from cnt=5
        cyc();
        check("pre_drain_gray", gray_clk_out, gray_of(5));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("drain_first_gray", gray_clk_out, gray_of(6));
        drain_to_zero("drain_up", 1019);
        for (int i = 0; i < 50; i++) begin
            cyc();
            check_all_zero("drain_hold");
        end

        // Start during drain cancels it and the run continues past 0
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 1020; i++) cyc();
        check("cancel_pre_gray", gray_clk_out, gray_of(1020));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        check("cancel_drain_gray", gray_clk_out, gray_of(1022));
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("cancel_hold_cnt", gray_clk_out, gray_of(1022));
        check("cancel_busy", busy, 1);
        cyc();
        cyc();
        check("cancel_wrap_strb", frame_strb, 1);
        check("cancel_wrap_busy", busy, 1);
        cyc();
        check("cancel_past0_gray", gray_clk_out, gray_of(1));
        check("cancel_past0_busy", busy, 1);
        check("cancel_past0_strb", frame_strb, 0);

        // Async reset at cnt=300 mid-run
        for (int i = 0; i < 299; i++) cyc();
        check("pre_rst_gray", gray_clk_out, gray_of(300));
        #2 rst = 1'b1;
        #1 check_all_zero("rst_midrun");
        cyc();
        rst = 1'b0;
        cyc();
        check_all_zero("rst_release_idle");

        // Down mode, with ud_en wiggled after start
        ud_en = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        ud_en = 1'b1;
        check("down_start_idx", no_ones_below_out, 7);
        check("down_start_gray", gray_clk_out, 0);
        check("down_start_busy", busy, 1);
        cyc();
        check("down1_gray", gray_clk_out, 32'h200);
        check("down1_idx", no_ones_below_out, 0);
        cyc();
        ud_en = 1'b0;
        check("down2_gray", gray_clk_out, 32'h201);
        check("down2_idx", no_ones_below_out, 1);
        cyc();
        check("down3_gray", gray_clk_out, 32'h203);
        check("down3_idx", no_ones_below_out, 0);
        cyc();
        check("down4_gray", gray_clk_out, 32'h202);
        check("down4_idx", no_ones_below_out, 2);
        check("down4_div2", clkdiv2, 0);

        // Drain in down mode from cnt=1020
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("down_drain_gray", gray_clk_out, gray_of(1019));
        drain_to_zero("drain_down", 1020);
        check("drain_down_idx", no_ones_below_out, 7);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("down_hold", {22'd0, gray_clk_out, no_ones_below_out, clkdiv2, frame_strb, busy},
                  {22'd0, 10'd0, 3'd7, 1'b0, 1'b0, 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
